// File: rtl/latq_bank_write_sequencer.sv
// Write sequencer for a latch-based register file: each accepted write drives D,
// opens one latch enable, then holds D, so D is stable across the transparent window.
module latq_bank_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_lat_d,
  output logic [DEPTH-1:0] o_lat_e,
  output logic             o_busy,
  output logic             o_err
);

  localparam int MAXC = (SETUP_CYC > OPEN_CYC)
                      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                      : ((OPEN_CYC  > HOLD_CYC) ? OPEN_CYC  : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_lat_d;
  logic [DEPTH-1:0] r_lat_e;
  logic             r_busy;
  logic             r_err;
  logic [DEPTH-1:0] w_onehot;
  logic             w_accept;
  logic             w_last;

  assign o_wr_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_last     = (r_cnt == CW'(1));

  // An out-of-range address matches no index below DEPTH, so LAT_E stays 0 for it.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DEPTH; i++)
      w_onehot[i] = (r_addr == AW'(i));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_lat_d <= '0;
      r_lat_e <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_cnt   <= CW'(SETUP_CYC);
            r_addr  <= i_wr_addr;
            r_lat_d <= i_wr_data;
            r_busy  <= 1'b1;
            r_err   <= ({1'b0, i_wr_addr} >= (AW+1)'(DEPTH));
          end
        end
        S_SETUP: begin
          if (w_last) begin
            r_state <= S_OPEN;
            r_cnt   <= CW'(OPEN_CYC);
            r_lat_e <= w_onehot;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_OPEN: begin
          if (w_last) begin
            r_state <= S_HOLD;
            r_cnt   <= CW'(HOLD_CYC);
            r_lat_e <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_lat_e <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_lat_d = r_lat_d;
  assign o_lat_e = r_lat_e;
  assign o_busy  = r_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_latq_bank_write_sequencer.sv
// Directed bench: default instance, a DEPTH=6 instance and a 2/3/2 timing instance.
module tb_latq_bank_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // dut0: defaults
  logic       rst0, vld0, rdy0, busy0, err0;
  logic [2:0] addr0;
  logic [7:0] data0, latd0, late0;
  // dut1: DEPTH=6
  logic       rst1, vld1, rdy1, busy1, err1;
  logic [2:0] addr1;
  logic [7:0] data1, latd1;
  logic [5:0] late1;
  // dut2: SETUP=2 OPEN=3 HOLD=2
  logic       rst2, vld2, rdy2, busy2, err2;
  logic [2:0] addr2;
  logic [7:0] data2, latd2, late2;

  latq_bank_write_sequencer u_dut0 (
    .i_clk(clk), .i_rst(rst0), .i_wr_valid(vld0), .o_wr_ready(rdy0),
    .i_wr_addr(addr0), .i_wr_data(data0), .o_lat_d(latd0), .o_lat_e(late0),
    .o_busy(busy0), .o_err(err0));

  latq_bank_write_sequencer #(.DEPTH(6)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_wr_valid(vld1), .o_wr_ready(rdy1),
    .i_wr_addr(addr1), .i_wr_data(data1), .o_lat_d(latd1), .o_lat_e(late1),
    .o_busy(busy1), .o_err(err1));

  latq_bank_write_sequencer #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_wr_valid(vld2), .o_wr_ready(rdy2),
    .i_wr_addr(addr2), .i_wr_data(data2), .o_lat_d(latd2), .o_lat_e(late2),
    .o_busy(busy2), .o_err(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1; rst2 = 1;
    vld0 = 0; vld1 = 0; vld2 = 0;
    addr0 = 0; addr1 = 0; addr2 = 0;
    data0 = 0; data1 = 0; data2 = 0;
    tick(); tick();
    total++; if (rdy0 !== 1'b0) $display("FAIL reset_ready_in_rst got %b exp 0", rdy0); else passed++;
    rst0 = 0; rst1 = 0; rst2 = 0;
    #1;
    total++; if (late0 !== 8'h00) $display("FAIL reset_lat_e got %h exp 00", late0); else passed++;
    total++; if (latd0 !== 8'h00) $display("FAIL reset_lat_d got %h exp 00", latd0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy0); else passed++;
    total++; if (err0 !== 1'b0) $display("FAIL reset_err got %b exp 0", err0); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL reset_ready_after got %b exp 1", rdy0); else passed++;
    total++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) $display("FAIL reset_ready_others got %b%b exp 11", rdy1, rdy2); else passed++;
  endtask

  task automatic test_single_write();
    vld0 = 1; addr0 = 3'd3; data0 = 8'hA5;
    tick();
    vld0 = 0; addr0 = 0; data0 = 0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (late0 !== ((k == 2) ? 8'h08 : 8'h00)) $display("FAIL write_lat_e k=%0d got %h exp %h", k, late0, (k == 2) ? 8'h08 : 8'h00); else passed++;
      total++; if (latd0 !== 8'hA5) $display("FAIL write_lat_d k=%0d got %h exp a5", k, latd0); else passed++;
      total++; if (busy0 !== (k <= 3)) $display("FAIL write_busy k=%0d got %b exp %b", k, busy0, k <= 3); else passed++;
      total++; if (rdy0 !== (k >= 4)) $display("FAIL write_ready k=%0d got %b exp %b", k, rdy0, k >= 4); else passed++;
      total++; if (err0 !== 1'b0) $display("FAIL write_err k=%0d got %b exp 0", k, err0); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d, exp_e;
    vld0 = 1; addr0 = 3'd0; data0 = 8'h11;
    tick();
    addr0 = 3'd7; data0 = 8'h22;
    for (int k = 1; k <= 9; k++) begin
      exp_d = (k <= 4) ? 8'h11 : 8'h22;
      exp_e = (k == 2) ? 8'h01 : (k == 6) ? 8'h80 : 8'h00;
      total++; if (late0 !== exp_e) $display("FAIL b2b_lat_e k=%0d got %h exp %h", k, late0, exp_e); else passed++;
      total++; if ($countones(late0) > 1) $display("FAIL b2b_onehot k=%0d got %h exp at most one bit", k, late0); else passed++;
      total++; if (latd0 !== exp_d) $display("FAIL b2b_lat_d k=%0d got %h exp %h", k, latd0, exp_d); else passed++;
      total++; if (rdy0 !== (k == 4 || k >= 8)) $display("FAIL b2b_ready k=%0d got %b exp %b", k, rdy0, k == 4 || k >= 8); else passed++;
      total++; if (busy0 !== ((k <= 3) || (k >= 5 && k <= 7))) $display("FAIL b2b_busy k=%0d got %b", k, busy0); else passed++;
      if (k == 5) begin vld0 = 0; addr0 = 0; data0 = 0; end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    vld1 = 1; addr1 = 3'd6; data1 = 8'h3C;
    tick();
    vld1 = 0; addr1 = 0; data1 = 0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (err1 !== (k == 1)) $display("FAIL oor_err k=%0d got %b exp %b", k, err1, k == 1); else passed++;
      total++; if (late1 !== 6'h00) $display("FAIL oor_lat_e k=%0d got %h exp 00", k, late1); else passed++;
      total++; if (rdy1 !== (k >= 4)) $display("FAIL oor_ready k=%0d got %b exp %b", k, rdy1, k >= 4); else passed++;
      total++; if (busy1 !== (k <= 3)) $display("FAIL oor_busy k=%0d got %b exp %b", k, busy1, k <= 3); else passed++;
      total++; if (latd1 !== 8'h3C) $display("FAIL oor_lat_d k=%0d got %h exp 3c", k, latd1); else passed++;
      tick();
    end
  endtask

  task automatic test_long_timing();
    vld2 = 1; addr2 = 3'd1; data2 = 8'h5A;
    tick();
    vld2 = 0; addr2 = 0; data2 = 0;
    for (int k = 1; k <= 9; k++) begin
      total++; if (late2 !== ((k >= 3 && k <= 5) ? 8'h02 : 8'h00)) $display("FAIL long_lat_e k=%0d got %h exp %h", k, late2, (k >= 3 && k <= 5) ? 8'h02 : 8'h00); else passed++;
      total++; if (latd2 !== 8'h5A) $display("FAIL long_lat_d k=%0d got %h exp 5a", k, latd2); else passed++;
      total++; if (busy2 !== (k <= 7)) $display("FAIL long_busy k=%0d got %b exp %b", k, busy2, k <= 7); else passed++;
      total++; if (rdy2 !== (k >= 8)) $display("FAIL long_ready k=%0d got %b exp %b", k, rdy2, k >= 8); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_sequence();
    vld0 = 1; addr0 = 3'd2; data0 = 8'h77;
    tick();
    vld0 = 0;
    tick();
    total++; if (late0 !== 8'h04) $display("FAIL midrst_open got %h exp 04", late0); else passed++;
    rst0 = 1;
    tick();
    total++; if (late0 !== 8'h00) $display("FAIL midrst_lat_e got %h exp 00", late0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy0); else passed++;
    total++; if (latd0 !== 8'h00) $display("FAIL midrst_lat_d got %h exp 00", latd0); else passed++;
    // reset wins over a simultaneous request
    vld0 = 1; addr0 = 3'd5; data0 = 8'h99;
    tick();
    total++; if (busy0 !== 1'b0 || latd0 !== 8'h00) $display("FAIL rst_vs_valid got busy=%b d=%h exp 0/00", busy0, latd0); else passed++;
    rst0 = 0;
    #1;
    total++; if (rdy0 !== 1'b1) $display("FAIL midrst_ready got %b exp 1", rdy0); else passed++;
    tick();
    vld0 = 0; addr0 = 0; data0 = 0;
    for (int k = 1; k <= 4; k++) begin
      total++; if (late0 !== ((k == 2) ? 8'h20 : 8'h00)) $display("FAIL post_rst_lat_e k=%0d got %h exp %h", k, late0, (k == 2) ? 8'h20 : 8'h00); else passed++;
      total++; if (latd0 !== 8'h99) $display("FAIL post_rst_lat_d k=%0d got %h exp 99", k, latd0); else passed++;
      total++; if (rdy0 !== (k == 4)) $display("FAIL post_rst_ready k=%0d got %b exp %b", k, rdy0, k == 4); else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_out_of_range();
    test_long_timing();
    test_reset_mid_sequence();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
